// File: rtl/ofw_ring_pkg.sv
// Shared constants and the issue-register layout for the overflow-ring writer.
package ofw_ring_pkg;

  localparam logic [2:0] AXSIZE_64B  = 3'b110;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BYTE_SHIFT  = 6;

  typedef struct packed {
    logic [63:0]  addr;
    logic [511:0] data;
    logic         aw_pend;
    logic         w_pend;
  } ofw_issue_t;

endpackage

// File: rtl/ofw_ring_ptr.sv
// Ring tail pointer: wrap-around advance and one-slot-empty full detection.
module ofw_ring_ptr #(
  parameter int IDX_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] last_idx_i,
  input  logic [IDX_W-1:0] head_idx_i,
  output logic [IDX_W-1:0] tail_o,
  output logic             full_o
);

  logic [IDX_W-1:0] tail_q, tail_d, next_idx;

  assign next_idx = (tail_q == last_idx_i) ? '0 : tail_q + IDX_W'(1);
  // A head beyond last_idx can never equal next_idx, so it never reports full.
  assign full_o   = (next_idx == head_idx_i);
  assign tail_o   = tail_q;

  always_comb begin
    tail_d = tail_q;
    if (clr_i)      tail_d = '0;
    else if (adv_i) tail_d = next_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tail_q <= '0;
    else         tail_q <= tail_d;
  end

endmodule

// File: rtl/ofw_ring_wr_afu.sv
// Overflow-ring writer: pops 64 B records and writes them into a circular buffer
// with up to MAX_OUTST writes awaiting B, AW and W handshaking independently.
module ofw_ring_wr_afu
  import ofw_ring_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int IDX_W     = 32
) (
  input  logic             axi4_mm_clk,
  input  logic             axi4_mm_rst_n,
  output logic [11:0]      awid,
  output logic [63:0]      awaddr,
  output logic [9:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic [5:0]       awuser,
  output logic             awvalid,
  input  logic             awready,
  output logic [2:0]       awprot,
  output logic [3:0]       awqos,
  output logic [3:0]       awcache,
  output logic [1:0]       awlock,
  output logic [3:0]       awregion,
  output logic [5:0]       awatop,
  output logic [511:0]     wdata,
  output logic [63:0]      wstrb,
  output logic             wlast,
  output logic             wuser,
  output logic             wvalid,
  input  logic             wready,
  input  logic [11:0]      bid,
  input  logic [1:0]       bresp,
  input  logic [3:0]       buser,
  input  logic             bvalid,
  output logic             bready,
  output logic [11:0]      arid,
  output logic [63:0]      araddr,
  output logic [9:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic [2:0]       arprot,
  output logic [3:0]       arqos,
  output logic [4:0]       aruser,
  output logic             arvalid,
  output logic [3:0]       arcache,
  output logic [1:0]       arlock,
  output logic [3:0]       arregion,
  input  logic             arready,
  input  logic [11:0]      rid,
  input  logic [511:0]     rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             ruser,
  input  logic             rvalid,
  output logic             rready,
  input  logic             csr_enable,
  input  logic [5:0]       csr_awuser,
  input  logic [63:0]      csr_buf_base,
  input  logic [IDX_W-1:0] csr_buf_last_idx,
  input  logic [IDX_W-1:0] buf_head_idx,
  output logic [63:0]      buf_vld_cnt,
  output logic [31:0]      buf_err_cnt,
  output logic             buf_full,
  output logic             busy,
  input  logic             ofw_q_empty,
  output logic             ofw_q_rdreq,
  input  logic [511:0]     ofw_q_rddata
);

  localparam int SEQ_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OUT_W = $clog2(MAX_OUTST) + 1;

  logic             run_q, run_d;
  logic [63:0]      base_q, base_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [5:0]       awuser_q, awuser_d;
  ofw_issue_t       iss_q, iss_d;
  logic [11:0]      id_q, id_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [63:0]      vld_q, vld_d;
  logic [31:0]      err_q, err_d;

  logic [IDX_W-1:0] tail;
  logic             full, pop, aw_hs, w_hs, b_hs, iss_free, busy_w, ptr_clr;
  logic             unused_inputs;

  assign aw_hs    = iss_q.aw_pend & awready;
  assign w_hs     = iss_q.w_pend & wready;
  assign iss_free = (~iss_q.aw_pend | awready) & (~iss_q.w_pend | wready);
  assign b_hs     = bvalid & bready;
  assign busy_w   = iss_q.aw_pend | iss_q.w_pend | (outst_q != '0);
  assign pop      = run_q & ~ofw_q_empty & iss_free & ~full
                  & (outst_q < OUT_W'(MAX_OUTST));
  assign ptr_clr  = ~run_q & ~busy_w;

  ofw_ring_ptr #(.IDX_W(IDX_W)) u_ptr (
    .clk_i      (axi4_mm_clk),
    .rst_ni     (axi4_mm_rst_n),
    .adv_i      (pop),
    .clr_i      (ptr_clr),
    .last_idx_i (last_q),
    .head_idx_i (buf_head_idx),
    .tail_o     (tail),
    .full_o     (full)
  );

  always_comb begin
    run_d    = run_q;
    base_d   = base_q;
    last_d   = last_q;
    awuser_d = awuser_q;
    iss_d    = iss_q;
    id_d     = id_q;
    seq_d    = seq_q;
    outst_d  = outst_q;
    vld_d    = vld_q;
    err_d    = err_q;

    // A re-enable during drain waits until the last write has retired.
    if (!run_q && csr_enable && !busy_w) begin
      run_d    = 1'b1;
      base_d   = csr_buf_base;
      last_d   = csr_buf_last_idx;
      awuser_d = csr_awuser;
    end else if (!csr_enable) begin
      run_d = 1'b0;
    end

    if (aw_hs) iss_d.aw_pend = 1'b0;
    if (w_hs)  iss_d.w_pend  = 1'b0;
    if (pop) begin
      iss_d.addr    = base_q + (64'(tail) << BYTE_SHIFT);
      iss_d.data    = ofw_q_rddata;
      iss_d.aw_pend = 1'b1;
      iss_d.w_pend  = 1'b1;
      id_d          = (MAX_OUTST > 1) ? 12'(seq_q) : 12'd0;
      seq_d         = seq_q + SEQ_W'(1);
    end

    case ({pop, b_hs})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (b_hs) begin
      vld_d = vld_q + 64'd1;
      if (bresp != RESP_OKAY && err_q != '1) err_d = err_q + 32'd1;
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      run_q    <= 1'b0;
      base_q   <= '0;
      last_q   <= '0;
      awuser_q <= '0;
      iss_q    <= '0;
      id_q     <= '0;
      seq_q    <= '0;
      outst_q  <= '0;
      vld_q    <= '0;
      err_q    <= '0;
    end else begin
      run_q    <= run_d;
      base_q   <= base_d;
      last_q   <= last_d;
      awuser_q <= awuser_d;
      iss_q    <= iss_d;
      id_q     <= id_d;
      seq_q    <= seq_d;
      outst_q  <= outst_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign awid     = id_q;
  assign awaddr   = iss_q.addr;
  assign awlen    = '0;
  assign awsize   = AXSIZE_64B;
  assign awburst  = BURST_FIXED;
  assign awuser   = awuser_q;
  assign awvalid  = iss_q.aw_pend;
  assign awprot   = '0;
  assign awqos    = '0;
  assign awcache  = '0;
  assign awlock   = '0;
  assign awregion = '0;
  assign awatop   = '0;
  assign wdata    = iss_q.data;
  assign wstrb    = '1;
  assign wlast    = 1'b1;
  assign wuser    = 1'b0;
  assign wvalid   = iss_q.w_pend;
  assign bready   = (outst_q != '0);

  assign arid     = '0;
  assign araddr   = '0;
  assign arlen    = '0;
  assign arsize   = '0;
  assign arburst  = '0;
  assign arprot   = '0;
  assign arqos    = '0;
  assign aruser   = '0;
  assign arvalid  = 1'b0;
  assign arcache  = '0;
  assign arlock   = '0;
  assign arregion = '0;
  assign rready   = 1'b0;

  assign buf_vld_cnt = vld_q;
  assign buf_err_cnt = err_q;
  // Ring geometry is only meaningful once latched, so full is reported while running.
  assign buf_full    = run_q & full;
  assign busy        = busy_w;
  assign ofw_q_rdreq = pop;

  assign unused_inputs = ^{bid, buser, arready, rid, rdata, rresp, rlast, ruser, rvalid};

endmodule

// File: tb/tb_ofw_ring_wr_afu.sv
// Directed bench for ofw_ring_wr_afu: show-ahead queue model, AW/W logger and B responder.
module tb_ofw_ring_wr_afu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] awid;  logic [63:0] awaddr; logic [9:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst; logic [5:0] awuser; logic awvalid; logic awready = 1'b1;
  logic [2:0] awprot; logic [3:0] awqos; logic [3:0] awcache; logic [1:0] awlock;
  logic [3:0] awregion; logic [5:0] awatop;
  logic [511:0] wdata; logic [63:0] wstrb; logic wlast, wuser, wvalid; logic wready = 1'b1;
  logic [1:0] bresp; logic bvalid, bready;
  logic [11:0] arid; logic [63:0] araddr; logic [9:0] arlen; logic [2:0] arsize;
  logic [1:0] arburst; logic [2:0] arprot; logic [3:0] arqos; logic [4:0] aruser;
  logic arvalid; logic [3:0] arcache; logic [1:0] arlock; logic [3:0] arregion; logic rready;
  logic csr_enable = 1'b0; logic [5:0] csr_awuser = '0; logic [63:0] csr_buf_base = '0;
  logic [31:0] csr_buf_last_idx = '0; logic [31:0] buf_head_idx = '0;
  logic [63:0] buf_vld_cnt; logic [31:0] buf_err_cnt; logic buf_full, busy;
  logic ofw_q_empty, ofw_q_rdreq; logic [511:0] ofw_q_rddata;

  int q_cnt = 0, q_rd = 0, aw_cnt = 0, w_cnt = 0, b_sent = 0;
  bit b_en = 1'b1;
  bit err_tbl [0:63];
  logic [63:0] aw_log [0:63];
  int n_chk = 0, n_pass = 0;

  function automatic logic [511:0] qd(input int k);
    return {16{32'hD000_0000 | 32'(k)}};
  endfunction

  assign ofw_q_empty  = (q_rd >= q_cnt);
  assign ofw_q_rddata = qd(q_rd);
  assign bvalid = b_en && (((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_sent);
  assign bresp  = err_tbl[b_sent] ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (awvalid && awready) begin aw_log[aw_cnt] <= awaddr; aw_cnt <= aw_cnt + 1; end
    if (wvalid && wready) w_cnt <= w_cnt + 1;
    if (bvalid && bready) b_sent <= b_sent + 1;
    if (ofw_q_rdreq && !ofw_q_empty) q_rd <= q_rd + 1;
  end

  ofw_ring_wr_afu #(.MAX_OUTST(4), .IDX_W(32)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awuser(awuser), .awvalid(awvalid), .awready(awready), .awprot(awprot), .awqos(awqos),
    .awcache(awcache), .awlock(awlock), .awregion(awregion), .awatop(awatop),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
    .bid(12'd0), .bresp(bresp), .buser(4'd0), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arprot(arprot), .arqos(arqos), .aruser(aruser), .arvalid(arvalid), .arcache(arcache),
    .arlock(arlock), .arregion(arregion), .arready(1'b0),
    .rid(12'd0), .rdata(512'd0), .rresp(2'd0), .rlast(1'b0), .ruser(1'b0), .rvalid(1'b0),
    .rready(rready),
    .csr_enable(csr_enable), .csr_awuser(csr_awuser), .csr_buf_base(csr_buf_base),
    .csr_buf_last_idx(csr_buf_last_idx), .buf_head_idx(buf_head_idx),
    .buf_vld_cnt(buf_vld_cnt), .buf_err_cnt(buf_err_cnt), .buf_full(buf_full), .busy(busy),
    .ofw_q_empty(ofw_q_empty), .ofw_q_rdreq(ofw_q_rdreq), .ofw_q_rddata(ofw_q_rddata)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (!busy && (ofw_q_empty || !csr_enable)) break;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) err_tbl[i] = 1'b0;

    // Reset state
    step(); step();
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_rdreq", ofw_q_rdreq, 1'b0);
    chk("rst_cnts", {buf_vld_cnt, buf_err_cnt, busy, buf_full, bready}, '0);
    chk("rst_wconst", {wstrb, wlast, wuser}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    chk("rst_awconst", {awlen, awsize, awburst, awprot, awqos, awcache, awlock, awregion, awatop},
        {10'd0, 3'b110, 2'd0, 3'd0, 4'd0, 4'd0, 2'd0, 4'd0, 6'd0});
    chk("ar_tie", {arid, araddr, arlen, arsize, arburst, arprot, arqos, aruser, arvalid,
                   arcache, arlock, arregion, rready}, '0);
    rst_n = 1'b1;
    step();

    // Basic write: three back-to-back records
    csr_buf_base = 64'h1000; csr_buf_last_idx = 7; buf_head_idx = 0; csr_awuser = 6'h2A;
    csr_enable = 1'b1; q_cnt = 3;
    step();
    chk("t1_rdreq", ofw_q_rdreq, 1'b1);
    step();
    chk("t1_aw0", {awvalid, wvalid, awaddr}, {1'b1, 1'b1, 64'h1000});
    chk("t1_wd0", wdata, qd(0));
    chk("t1_awuser", awuser, 6'h2A);
    step();
    chk("t1_aw1", {awvalid, awaddr, awid}, {1'b1, 64'h1040, 12'd1});
    step();
    chk("t1_aw2", {awvalid, awaddr}, {1'b1, 64'h1080});
    wait_idle("t1_idle");
    chk("t1_vld", buf_vld_cnt, 64'd3);

    // Outstanding limit: B withheld, eight records queued
    b_en = 1'b0; buf_head_idx = 3; q_cnt = 11;
    repeat (12) step();
    chk("t2_pops4", q_rd, 7);
    chk("t2_rdreq0", {ofw_q_rdreq, bready, busy}, {1'b0, 1'b1, 1'b1});
    b_en = 1'b1;
    step();
    b_en = 1'b0;
    repeat (6) step();
    chk("t2_pops5", q_rd, 8);
    chk("t2_vld1", buf_vld_cnt, 64'd4);
    buf_head_idx = 7; b_en = 1'b1;
    wait_idle("t2_idle");
    chk("t2_vld", {32'(q_rd), buf_vld_cnt}, {32'd11, 64'd11});

    // Decoupled channels: W before AW
    awready = 1'b0; q_cnt = 12;
    step();
    chk("t3a_both", {awvalid, wvalid, awaddr}, {1'b1, 1'b1, 64'h10C0});
    step();
    chk("t3a_wdone", {awvalid, wvalid}, 2'b10);
    repeat (3) step();
    chk("t3a_hold", {awvalid, awaddr, buf_vld_cnt}, {1'b1, 64'h10C0, 64'd11});
    awready = 1'b1;
    step();
    chk("t3a_awdone", awvalid, 1'b0);
    wait_idle("t3a_idle");
    chk("t3a_vld", buf_vld_cnt, 64'd12);
    // AW before W
    wready = 1'b0; q_cnt = 13;
    step(); step();
    chk("t3b_awdone", {awvalid, wvalid}, 2'b01);
    repeat (3) step();
    chk("t3b_hold", {wvalid, wdata}, {1'b1, qd(12)});
    wready = 1'b1;
    wait_idle("t3b_idle");
    chk("t3b_vld", buf_vld_cnt, 64'd13);

    // Wrap and full on a four-entry ring
    csr_enable = 1'b0;
    step(); step();
    csr_buf_last_idx = 3; buf_head_idx = 0; csr_enable = 1'b1; q_cnt = 18;
    repeat (10) step();
    chk("t4_cnt3", aw_cnt, 16);
    chk("t4_idx012", {aw_log[13], aw_log[14], aw_log[15]}, {64'h1000, 64'h1040, 64'h1080});
    chk("t4_full", {buf_full, ofw_q_rdreq}, 2'b10);
    buf_head_idx = 2;
    repeat (10) step();
    chk("t4_idx30", {32'(aw_cnt), aw_log[16], aw_log[17]}, {32'd18, 64'h10C0, 64'h1000});
    chk("t4_refull", {buf_full, buf_vld_cnt}, {1'b1, 64'd18});

    // Errors, then drain with three writes in flight
    csr_enable = 1'b0;
    wait_idle("t5_pre_idle");
    step();
    csr_buf_last_idx = 15; buf_head_idx = 0; csr_enable = 1'b1;
    err_tbl[19] = 1'b1; err_tbl[21] = 1'b1; q_cnt = 23;
    wait_idle("t5_idle");
    chk("t5_err", {buf_err_cnt, buf_vld_cnt}, {32'd2, 64'd23});
    b_en = 1'b0; q_cnt = 26;
    repeat (6) step();
    chk("t5_inflight", {32'(q_rd), busy, bready}, {32'd26, 1'b1, 1'b1});
    csr_enable = 1'b0;
    step();
    q_cnt = 27;
    repeat (4) step();
    chk("t5_nopop", {32'(q_rd), ofw_q_rdreq}, {32'd26, 1'b0});
    b_en = 1'b1;
    wait_idle("t5_drain");
    step();
    chk("t5_done", {buf_vld_cnt, buf_err_cnt, busy}, {64'd26, 32'd2, 1'b0});
    chk("t5_tail0", dut.u_ptr.tail_q, 32'd0);

    // Asynchronous reset while awvalid is high
    awready = 1'b0; csr_enable = 1'b1;
    for (int i = 0; i < 10 && !awvalid; i++) step();
    chk("t6_aw", {awvalid, awaddr, wdata}, {1'b1, 64'h1000, qd(26)});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {awvalid, wvalid, ofw_q_rdreq, bready, busy, buf_full}, '0);
    chk("t6_rst_cnt", {buf_vld_cnt, buf_err_cnt}, '0);
    chk("t6_rst_data", {awaddr, awid, awuser, wdata}, '0);
    chk("t6_rst_wstrb", {wstrb, wlast}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
